// File: rtl/alu_result_writeback.sv
// rtl/alu_result_writeback.sv - buffers 4-lane ALU result groups and serializes them into the result SRAM
module alu_result_writeback #(
    parameter int RES_W  = 18,
    parameter int RAM_DW = 32,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_res_valid,
    input  logic              i_res_last,
    input  logic [RES_W-1:0]  i_mu1,
    input  logic [RES_W-1:0]  i_mu2,
    input  logic [RES_W-1:0]  i_mu3,
    input  logic [RES_W-1:0]  i_mu4,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [RAM_DW-1:0] o_ram_wdata,
    output logic              o_busy,
    output logic              o_wb_done,
    output logic              o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Two-entry group buffer; lane 0 of each entry is mu1.
    logic [3:0][RES_W-1:0] r_mem [2];
    logic                  r_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic [1:0]            r_lane;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_overflow;
    logic                  r_wb_done;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [1:0]            w_count_nxt;
    logic [1:0]            w_lane_nxt;
    logic [RES_W-1:0]      w_lane_data;
    logic                  w_head_last;

    assign w_lane_data = r_mem[r_rd_ptr][r_lane];
    assign w_head_last = r_last[r_rd_ptr];

    // Issue/push/pop decisions and next-state logic; a write is issued at the
    // edge that leaves IDLE so the first SRAM write lands one cycle later.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_issue     = (r_state == S_WRITE) || ((r_state == S_IDLE) && (r_count != 2'd0));
        w_pop       = w_issue && (r_lane == 2'd3);
        w_push      = i_res_valid && ((r_count != 2'd2) || w_pop);
        w_drop      = i_res_valid && (r_count == 2'd2) && !w_pop;
        w_count_nxt = r_count - {1'b0, w_pop} + {1'b0, w_push};
        if (r_state == S_DONE) begin
            w_state_nxt = S_IDLE;
        end else if (w_issue) begin
            w_lane_nxt = r_lane + 2'd1;
            if (w_pop) begin
                if (w_head_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_count_nxt != 2'd0) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_state_nxt = S_WRITE;
            end
        end
    end

    // Control state: FSM, lane, buffer pointers/count, address counter, flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lane     <= 2'd0;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
            r_wb_done  <= 1'b0;
        end else if (i_start) begin
            r_state    <= S_IDLE;
            r_lane     <= 2'd0;
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_addr     <= '0;
            r_overflow <= 1'b0;
            r_wb_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lane    <= w_lane_nxt;
            r_count   <= w_count_nxt;
            r_wb_done <= (r_state == S_DONE);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Buffer storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_start) begin
            r_mem[r_wr_ptr]  <= {i_mu4, i_mu3, i_mu2, i_mu1};
            r_last[r_wr_ptr] <= i_res_last;
        end
    end

    // Registered SRAM port; address and data hold between writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ram_cs    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
        end else if (i_start) begin
            o_ram_cs <= 1'b0;
            o_ram_we <= 1'b0;
        end else begin
            o_ram_cs <= w_issue;
            o_ram_we <= w_issue;
            if (w_issue) begin
                o_ram_addr  <= r_addr;
                o_ram_wdata <= {{(RAM_DW-RES_W){1'b0}}, w_lane_data};
            end
        end
    end

    assign o_busy     = (r_count != 2'd0) || (r_state != S_IDLE);
    assign o_wb_done  = r_wb_done;
    assign o_overflow = r_overflow;

endmodule
